// File: rtl/jk_reg_bank_if.sv
// Bundles the mode/data inputs and q/qn/tc outputs of jk_reg_bank.
// The slave modport is the register bank; master is whoever drives it.
interface jk_reg_bank_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             dir;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             tc;

  modport master (
    output en, mode, j, k, dir, ser_in,
    input  q, qn, tc
  );

  modport slave (
    input  en, mode, j, k, dir, ser_in,
    output q, qn, tc
  );
endinterface

// File: rtl/jk_reg_bank.sv
// WIDTH-bit JK register bank with JK / up-down COUNT / SHIFT / LOAD modes and a registered tc.
// Optional build macro JKBANK_SAT_EN: COUNT saturates at the ends instead of wrapping.
module jk_reg_bank #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          clr,
  jk_reg_bank_if.slave bus
);

  typedef enum logic [1:0] {
    ModeJk    = 2'b00,
    ModeCount = 2'b01,
    ModeShift = 2'b10,
    ModeLoad  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_d, q_q;
  logic [WIDTH-1:0] qn_d, qn_q;
  logic             tc_d, tc_q;
  logic             at_top, at_bot, at_end;
  mode_e            mode;

  assign mode   = mode_e'(bus.mode);
  assign at_top = &q_q;
  assign at_bot = ~|q_q;
  // The end the counter is heading towards; reaching it past this edge is a wrap.
  assign at_end = bus.dir ? at_top : at_bot;

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (bus.en) begin
      unique case (mode)
        ModeJk: begin
          q_d = (bus.j & ~q_q) | (~bus.k & q_q);
        end
        ModeCount: begin
          tc_d = at_end;
`ifdef JKBANK_SAT_EN
          if (!at_end) begin
            q_d = bus.dir ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
          end
`else
          q_d = bus.dir ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
`endif
        end
        ModeShift: begin
          q_d = {q_q[WIDTH-2:0], bus.ser_in};
        end
        ModeLoad: begin
          q_d = bus.j;
        end
        default: begin
          q_d = q_q;
        end
      endcase
    end
    // Kept as its own register so qn carries no inverter delay after the clock.
    qn_d = ~q_d;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q  <= '0;
      qn_q <= '1;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      qn_q <= qn_d;
      tc_q <= tc_d;
    end
  end

  assign bus.q  = q_q;
  assign bus.qn = qn_q;
  assign bus.tc = tc_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank: a behavioural model pushes expected q/qn/tc per edge,
// which are popped and compared one step after the edge.
module tb_jk_reg_bank;
  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] qn;
    logic         tc;
  } exp_t;

  logic clk;
  logic clr;
  int   n_total;
  int   n_bad;

  exp_t         sb_q[$];
  logic [W-1:0] mdl_q;

  jk_reg_bank_if #(.WIDTH(W)) bus_if ();

  jk_reg_bank #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Independent model of one rising edge given the current model state.
  function automatic exp_t model_next(input logic c, input logic e, input logic [1:0] m,
                                      input logic [W-1:0] jv, input logic [W-1:0] kv,
                                      input logic d, input logic s);
    exp_t r;
    logic [W-1:0] nq;
    logic         ntc;
    nq  = mdl_q;
    ntc = 1'b0;
    if (c) begin
      nq = '0;
    end else if (e) begin
      case (m)
        2'b00: begin
          for (int i = 0; i < W; i++) begin
            case ({jv[i], kv[i]})
              2'b01:   nq[i] = 1'b0;
              2'b10:   nq[i] = 1'b1;
              2'b11:   nq[i] = ~mdl_q[i];
              default: nq[i] = mdl_q[i];
            endcase
          end
        end
        2'b01: begin
          if (d && mdl_q == {W{1'b1}}) begin
            ntc = 1'b1;
`ifdef JKBANK_SAT_EN
            nq = mdl_q;
`else
            nq = '0;
`endif
          end else if (!d && mdl_q == '0) begin
            ntc = 1'b1;
`ifdef JKBANK_SAT_EN
            nq = mdl_q;
`else
            nq = {W{1'b1}};
`endif
          end else begin
            nq = d ? W'(int'(mdl_q) + 1) : W'(int'(mdl_q) - 1);
          end
        end
        2'b10:   nq = (mdl_q << 1) | W'(s);
        default: nq = jv;
      endcase
    end
    r.q  = nq;
    r.qn = ~nq;
    r.tc = ntc;
    return r;
  endfunction

  // Drive one edge's worth of inputs, push the prediction, then pop and compare after the edge.
  task automatic cycle(input string tag, input logic c, input logic e, input logic [1:0] m,
                       input logic [W-1:0] jv, input logic [W-1:0] kv, input logic d,
                       input logic s);
    exp_t ex;
    exp_t got;
    @(negedge clk);
    clr           = c;
    bus_if.en     = e;
    bus_if.mode   = m;
    bus_if.j      = jv;
    bus_if.k      = kv;
    bus_if.dir    = d;
    bus_if.ser_in = s;
    ex = model_next(c, e, m, jv, kv, d, s);
    sb_q.push_back(ex);
    mdl_q = ex.q;
    @(posedge clk);
    #1;
    got.q  = bus_if.q;
    got.qn = bus_if.qn;
    got.tc = bus_if.tc;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      ex = sb_q.pop_front();
      check_val({tag, "_q"}, 32'(got.q), 32'(ex.q));
      check_val({tag, "_qn"}, 32'(got.qn), 32'(ex.qn));
      check_val({tag, "_tc"}, 32'(got.tc), 32'(ex.tc));
    end
  endtask

  initial begin
    n_total       = 0;
    n_bad         = 0;
    mdl_q         = '0;
    clr           = 1'b1;
    bus_if.en     = 1'b0;
    bus_if.mode   = 2'b00;
    bus_if.j      = '0;
    bus_if.k      = '0;
    bus_if.dir    = 1'b0;
    bus_if.ser_in = 1'b0;

    // Reset dominates LOAD with en=1.
    cycle("rst0", 1, 1, 2'b11, 8'hA5, 8'h00, 0, 0);
    cycle("rst1", 1, 1, 2'b11, 8'hA5, 8'h00, 0, 0);
    check_val("rst_q_lit", 32'(bus_if.q), 32'h00);
    check_val("rst_qn_lit", 32'(bus_if.qn), 32'hFF);
    cycle("load_a5", 0, 1, 2'b11, 8'hA5, 8'h00, 0, 0);
    check_val("load_qn_lit", 32'(bus_if.qn), 32'h5A);

    // JK truth table across all four j/k combinations.
    cycle("ld_0f", 0, 1, 2'b11, 8'h0F, 8'h00, 0, 0);
    cycle("jk", 0, 1, 2'b00, 8'hCC, 8'hAA, 0, 0);
    check_val("jk_q_lit", 32'(bus_if.q), 32'hC5);

    // Wrap up then down through the boundary, and all-ones with dir=0 (no tc).
    cycle("ld_fe", 0, 1, 2'b11, 8'hFE, 8'h00, 0, 0);
    cycle("up_ff", 0, 1, 2'b01, 8'h00, 8'h00, 1, 0);
    cycle("up_00", 0, 1, 2'b01, 8'h00, 8'h00, 1, 0);
    cycle("up_01", 0, 1, 2'b01, 8'h00, 8'h00, 1, 0);
    cycle("dn_00", 0, 1, 2'b01, 8'h00, 8'h00, 0, 0);
    cycle("dn_wrap", 0, 1, 2'b01, 8'h00, 8'h00, 0, 0);
    cycle("dn_fe", 0, 1, 2'b01, 8'h00, 8'h00, 0, 0);

    // Enable gating.
    cycle("ld_10", 0, 1, 2'b11, 8'h10, 8'h00, 0, 0);
    cycle("en1", 0, 1, 2'b01, 8'h00, 8'h00, 1, 0);
    cycle("en0", 0, 0, 2'b01, 8'h00, 8'h00, 1, 0);
    cycle("en1b", 0, 1, 2'b01, 8'h00, 8'h00, 1, 0);

    // Shift.
    cycle("ld_81", 0, 1, 2'b11, 8'h81, 8'h00, 0, 0);
    cycle("sh1", 0, 1, 2'b10, 8'h00, 8'h00, 0, 1);
    cycle("sh0", 0, 1, 2'b10, 8'h00, 8'h00, 0, 0);
    cycle("sh0b", 0, 1, 2'b10, 8'h00, 8'h00, 0, 0);

    // Saturation / pinned tc, then clr overriding a would-be wrap.
    cycle("ld_fe2", 0, 1, 2'b11, 8'hFE, 8'h00, 0, 0);
    cycle("sat0", 0, 1, 2'b01, 8'h00, 8'h00, 1, 0);
    cycle("sat1", 0, 1, 2'b01, 8'h00, 8'h00, 1, 0);
    cycle("sat2", 0, 1, 2'b01, 8'h00, 8'h00, 1, 0);
    cycle("clr_mid", 1, 1, 2'b01, 8'h00, 8'h00, 1, 0);

    // tc while disabled at the boundary, and in a non-COUNT mode.
    cycle("en0_bnd", 0, 0, 2'b01, 8'h00, 8'h00, 0, 0);
    cycle("jk_hold0", 0, 1, 2'b00, 8'h00, 8'h00, 0, 0);

    // Full up-count from zero: one tc pulse per 256 edges in the wrapping build.
    cycle("ld_00", 0, 1, 2'b11, 8'h00, 8'h00, 0, 0);
    for (int n = 0; n < 258; n++) begin
      cycle("full", 0, 1, 2'b01, 8'h00, 8'h00, 1, 0);
    end

    // Random mixed traffic with occasional clr.
    for (int n = 0; n < 200; n++) begin
      cycle("rnd", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom),
            1'($urandom));
    end

    if (sb_q.size() != 0) begin
      check_val("sb_leftover", 32'(sb_q.size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
